// File: rtl/riscv_soc.sv
// riscv_soc: RV32I system top with a single-cycle core, combinational instruction ROM and optional data RAM.
// Optional feature macro: DATA_RAM_EN adds ram_inst on the data bus; without it loads read 0 and stores drop.
// Reset rst is asynchronous and active-low; every instruction retires in the cycle it is fetched.

// Register file: 32 x 32 with two combinational read ports and one write port; x0 hardwired to zero.
// Latency: reads zero-cycle, write lands on posedge.
// Backpressure: none, always accepts a write.
module riscv_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_dat,
  output logic [31:0] rs2_dat,
  input  logic        rd_vld,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_dat
);
  logic [31:0] regs [0:31];

  // Clear everything on reset; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (rd_vld && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_dat;
    end
  end

  assign rs1_dat = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
  assign rs2_dat = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];
endmodule

// Core: single-cycle RV32I; fetch, decode, execute, memory and writeback all in one clock.
// Latency: one instruction per cycle, data reads zero-cycle, stores committed on posedge.
// Backpressure: none; unknown or zero encodings execute as a no-op and advance the PC.
module riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc, pc_next;
  logic [31:0] rs1_dat, rs2_dat, rd_dat, load_sh;
  logic        rd_vld, take;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'h000};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  riscv_regs regs_inst (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (inst_i[19:15]),
    .rs2_addr (inst_i[24:20]),
    .rs1_dat  (rs1_dat),
    .rs2_dat  (rs2_dat),
    .rd_vld   (rd_vld),
    .rd_addr  (inst_i[11:7]),
    .rd_dat   (rd_dat)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'h0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'h0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Loads and stores share one address adder; the byte offset steers lanes both ways.
  assign mem_addr_o  = rs1_dat + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign byte_off    = mem_addr_o[1:0];
  assign load_sh     = mem_rdata_i >> {byte_off, 3'b000};
  assign inst_addr_o = pc;

  // Branch condition evaluation.
  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = (rs1_dat == rs2_dat);
      3'b001:  take = (rs1_dat != rs2_dat);
      3'b100:  take = ($signed(rs1_dat) <  $signed(rs2_dat));
      3'b101:  take = ($signed(rs1_dat) >= $signed(rs2_dat));
      3'b110:  take = (rs1_dat <  rs2_dat);
      3'b111:  take = (rs1_dat >= rs2_dat);
      default: take = 1'b0;
    endcase
  end

  // Decode and execute: next PC, writeback and store lane selection.
  always_comb begin
    pc_next     = pc + 32'd4;
    rd_vld      = 1'b0;
    rd_dat      = 32'h0;
    mem_we_o    = 1'b0;
    mem_wstrb_o = 4'h0;
    mem_wdata_o = 32'h0;
    case (opcode)
      OP_LUI:   begin rd_vld = 1'b1; rd_dat = imm_u; end
      OP_AUIPC: begin rd_vld = 1'b1; rd_dat = pc + imm_u; end
      OP_JAL: begin
        rd_vld  = 1'b1;
        rd_dat  = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rd_vld  = 1'b1;
          rd_dat  = pc + 32'd4;
          pc_next = (rs1_dat + imm_i) & ~32'h1;
        end
      end
      OP_BRANCH: if (take) pc_next = pc + imm_b;
      OP_LOAD: begin
        rd_vld = 1'b1;
        case (funct3)
          3'b000:  rd_dat = {{24{load_sh[7]}}, load_sh[7:0]};
          3'b001:  rd_dat = {{16{load_sh[15]}}, load_sh[15:0]};
          3'b010:  rd_dat = mem_rdata_i;
          3'b100:  rd_dat = {24'h0, load_sh[7:0]};
          3'b101:  rd_dat = {16'h0, load_sh[15:0]};
          default: rd_vld = 1'b0;
        endcase
      end
      OP_STORE: begin
        case (funct3)
          3'b000: begin
            mem_we_o    = 1'b1;
            mem_wstrb_o = 4'b0001 << byte_off;
            mem_wdata_o = rs2_dat << {byte_off, 3'b000};
          end
          3'b001: begin
            mem_we_o    = 1'b1;
            mem_wstrb_o = 4'b0011 << byte_off;
            mem_wdata_o = rs2_dat << {byte_off, 3'b000};
          end
          3'b010: begin
            mem_we_o    = 1'b1;
            mem_wstrb_o = 4'b1111;
            mem_wdata_o = rs2_dat;
          end
          default: mem_we_o = 1'b0;
        endcase
      end
      OP_IMM: begin
        rd_vld = 1'b1;
        rd_dat = alu(rs1_dat, imm_i, funct3, (funct3 == 3'b101) && inst_i[30]);
      end
      OP_REG: begin
        rd_vld = 1'b1;
        rd_dat = alu(rs1_dat, rs2_dat, funct3, inst_i[30]);
      end
      default: ;
    endcase
  end

  // Program counter; reset forces RESET_PC so the first fetch after release comes from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end
endmodule

// Instruction ROM: word array indexed by address bits above the byte offset, aliasing modulo DEPTH*4.
// Latency: zero-cycle combinational read.
// Backpressure: none.
module riscv_rom #(
  parameter int DEPTH = 4096
) (
  input  logic [31:0] addr,
  output logic [31:0] data
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] rom_mem [0:DEPTH-1];
  logic        unused_addr;

  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign data        = rom_mem[addr[AW+1:2]];
endmodule

`ifdef DATA_RAM_EN
// Data RAM: byte-lane write-strobed storage, contents kept across reset.
// Latency: combinational read, write committed on posedge.
// Backpressure: none.
module riscv_ram #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram_mem [0:DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign rdata       = ram_mem[idx];

  // Per-lane write; untouched lanes keep their old bytes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && wstrb[i]) ram_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end
endmodule
`endif

// SoC top: wires core fetch port to the ROM and data port to the RAM (or a zero source).
// Latency: inherited from the core, one instruction per cycle.
// Backpressure: none; no top-level outputs.
module riscv_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);
  logic [31:0] inst_addr, inst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_wstrb;

  riscv_core #(.RESET_PC(RESET_PC)) riscv_inst (
    .clk         (clk),
    .rst_n       (rst),
    .inst_addr_o (inst_addr),
    .inst_i      (inst),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_wstrb_o (mem_wstrb),
    .mem_rdata_i (mem_rdata)
  );

  riscv_rom #(.DEPTH(ROM_DEPTH)) rom_inst (
    .addr (inst_addr),
    .data (inst)
  );

`ifdef DATA_RAM_EN
  riscv_ram #(.DEPTH(RAM_DEPTH)) ram_inst (
    .clk   (clk),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .we    (mem_we),
    .wstrb (mem_wstrb),
    .rdata (mem_rdata)
  );
`else
  // No data memory: loads see zero and stores have nowhere to land.
  localparam int unused_ram_depth = RAM_DEPTH;
  logic unused_dbus;
  assign unused_dbus = ^{mem_addr, mem_wdata, mem_we, mem_wstrb};
  assign mem_rdata   = 32'h0;
`endif
endmodule

// File: tb/tb_riscv_soc.sv
// Bench for riscv_soc: loads small programs into rom_mem, drives reset, checks registers via a scoreboard.
`timescale 1ns/1ps
module tb_riscv_soc;
  logic clk = 1'b1;
  logic rst;

  always #10 clk = ~clk;

  riscv_soc dut (.clk(clk), .rst(rst));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  real  t_done;

  function automatic logic [31:0] rd_reg(input logic [4:0] n);
    return dut.riscv_inst.regs_inst.regs[n];
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_underflow observed=%h required=queued_entry", obs);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    // ---------------- Test 1: ISA-style program ----------------
    rst = 1'b0;
    clear_rom();
    dut.rom_inst.rom_mem[0]  = enc_i(12'd2, 5'd0, 3'b000, 5'd3, 7'h13);       // addi x3,x0,2
    dut.rom_inst.rom_mem[1]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);       // addi x1,x0,5
    dut.rom_inst.rom_mem[2]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13);     // addi x2,x0,-3
    dut.rom_inst.rom_mem[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4);        // add x4,x1,x2
    dut.rom_inst.rom_mem[4]  = enc_i(12'd2, 5'd0, 3'b000, 5'd5, 7'h13);       // addi x5,x0,2
    dut.rom_inst.rom_mem[5]  = enc_b(13'h030, 5'd5, 5'd4, 3'b001);            // bne x4,x5,fail
    dut.rom_inst.rom_mem[6]  = enc_u(20'h11223, 5'd6, 7'h37);                 // lui x6,0x11223
    dut.rom_inst.rom_mem[7]  = enc_i(12'h344, 5'd6, 3'b000, 5'd6, 7'h13);     // addi x6,x6,0x344
    dut.rom_inst.rom_mem[8]  = enc_i(12'h100, 5'd0, 3'b000, 5'd7, 7'h13);     // addi x7,x0,0x100
    dut.rom_inst.rom_mem[9]  = enc_s(12'd0, 5'd6, 5'd7, 3'b010);              // sw x6,0(x7)
    dut.rom_inst.rom_mem[10] = enc_i(12'h0AA, 5'd0, 3'b000, 5'd8, 7'h13);     // addi x8,x0,0xAA
    dut.rom_inst.rom_mem[11] = enc_s(12'd1, 5'd8, 5'd7, 3'b000);              // sb x8,1(x7)
    dut.rom_inst.rom_mem[12] = enc_i(12'd0, 5'd7, 3'b010, 5'd9, 7'h03);       // lw x9,0(x7)
    dut.rom_inst.rom_mem[13] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd10);       // sub x10,x1,x2
    dut.rom_inst.rom_mem[14] = enc_i(12'd1, 5'd0, 3'b000, 5'd27, 7'h13);      // addi x27,x0,1
    dut.rom_inst.rom_mem[15] = enc_i(12'd1, 5'd0, 3'b000, 5'd26, 7'h13);      // addi x26,x0,1
    dut.rom_inst.rom_mem[16] = enc_j(21'd0, 5'd0);                            // jal x0,0
    dut.rom_inst.rom_mem[17] = enc_i(12'd2, 5'd0, 3'b000, 5'd27, 7'h13);      // fail: addi x27,x0,2
    dut.rom_inst.rom_mem[18] = enc_i(12'd1, 5'd0, 3'b000, 5'd26, 7'h13);      // addi x26,x0,1
    dut.rom_inst.rom_mem[19] = enc_j(21'd0, 5'd0);                            // jal x0,0
    expect_val("pc_in_reset", 32'h0);
    expect_val("x26_done", 32'd1);
    expect_val("x27_pass", 32'd1);
    expect_val("x0_zero", 32'h0);
    expect_val("x1_addi", 32'd5);
    expect_val("x2_addi_neg", 32'hFFFF_FFFD);
    expect_val("x3_testnum", 32'd2);
    expect_val("x4_add", 32'd2);
    expect_val("x6_lui_addi", 32'h1122_3344);
`ifdef DATA_RAM_EN
    expect_val("x9_lw_after_sb", 32'h1122_AA44);
`else
    expect_val("x9_lw_no_ram", 32'h0);
`endif
    expect_val("x10_sub", 32'd8);

    #5;
    check_obs(dut.inst_addr);
    #25 rst = 1'b1;                                      // release at 30 ns
    for (int i = 0; i < 200 && rd_reg(5'd26) !== 32'd1; i++) begin
      @(posedge clk);
      #1;
    end
    t_done = $realtime;
    check_obs(rd_reg(5'd26));
    #200;
    check_obs(rd_reg(5'd27));
    if (rd_reg(5'd27) === 32'd1) begin
      $display("pass elapsed %0.3f us", t_done / 1000.0);
    end else begin
      for (int i = 0; i < 32; i++) $display("x%0d = %0d", i, rd_reg(i[4:0]));
    end
    check_obs(rd_reg(5'd0));
    check_obs(rd_reg(5'd1));
    check_obs(rd_reg(5'd2));
    check_obs(rd_reg(5'd3));
    check_obs(rd_reg(5'd4));
    check_obs(rd_reg(5'd6));
    check_obs(rd_reg(5'd9));
    check_obs(rd_reg(5'd10));

    // ---------------- Test 2: long reset with loaded ROM ----------------
    @(posedge clk);
    #5 rst = 1'b0;
    for (int i = 1; i < 32; i++) expect_val($sformatf("x%0d_held_reset", i), 32'h0);
    expect_val("pc_held_reset", 32'h0);
    #100;
    for (int i = 1; i < 32; i++) check_obs(rd_reg(i[4:0]));
    check_obs(dut.inst_addr);
    rst = 1'b1;
    expect_val("x3_first_fetch", 32'd2);
    expect_val("x1_not_yet", 32'h0);
    expect_val("pc_after_first", 32'h4);
    @(posedge clk);
    #1;
    check_obs(rd_reg(5'd3));
    check_obs(rd_reg(5'd1));
    check_obs(dut.inst_addr);

    // ---------------- Test 3: reset pulse mid-run ----------------
    rst = 1'b0;
    clear_rom();
    dut.rom_inst.rom_mem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'h13);        // addi x5,x0,7
    dut.rom_inst.rom_mem[1] = enc_j(21'd0, 5'd0);                             // jal x0,0
    expect_val("x5_before_pulse", 32'd7);
    expect_val("pc_spin", 32'h4);
    expect_val("x5_async_clear", 32'h0);
    expect_val("x5_no_write_in_reset", 32'h0);
    expect_val("pc_in_pulse", 32'h0);
    expect_val("x5_after_restart", 32'd7);
    #10 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_obs(rd_reg(5'd5));
    check_obs(dut.inst_addr);
    rst = 1'b0;
    #1;
    check_obs(rd_reg(5'd5));
    @(posedge clk);
    #1;
    check_obs(rd_reg(5'd5));
    check_obs(dut.inst_addr);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    check_obs(rd_reg(5'd5));

    // ---------------- Test 4: jalr beyond ROM aliases ----------------
    rst = 1'b0;
    clear_rom();
    dut.rom_inst.rom_mem[0] = enc_i(12'd1, 5'd10, 3'b000, 5'd10, 7'h13);      // addi x10,x10,1
    dut.rom_inst.rom_mem[1] = enc_u(20'h00004, 5'd11, 7'h37);                 // lui x11,0x4
    dut.rom_inst.rom_mem[2] = enc_i(12'd0, 5'd11, 3'b000, 5'd0, 7'h67);       // jalr x0,0(x11)
    expect_val("pc_jalr_target", 32'h0000_4000);
    expect_val("inst_aliased_word0", enc_i(12'd1, 5'd10, 3'b000, 5'd10, 7'h13));
    expect_val("x10_second_pass", 32'd2);
    expect_val("pc_after_alias", 32'h0000_4004);
    #5 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_obs(dut.inst_addr);
    check_obs(dut.inst);
    @(posedge clk);
    #1;
    check_obs(rd_reg(5'd10));
    check_obs(dut.inst_addr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
